// File: rtl/coin_classifier.sv
// coin_classifier
// Front-end coin acceptor stage for the vending controller. The block
// debounces the raw coin-present sensor and averages four coin-size samples.
// It then classifies the coin as 5, 10 or 25 cents, or rejects it.
// For an accepted coin it emits one fixed-length, one-hot detect pulse.
// For a rejected coin it emits one reject pulse of the same length.
// After either pulse it enforces a quiet gap before the next coin is accepted.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   coin_present  raw optical sensor (already synchronised, may bounce)
//   coin_size     unsigned size measurement, valid while coin_present = 1
//   detect_5      registered detect pulse, 5-cent coin
//   detect_10     registered detect pulse, 10-cent coin
//   detect_25     registered detect pulse, 25-cent coin
//   reject        registered pulse, coin diverted to the return chute
//   busy          high in every state except IDLE
//   accept_cnt    saturating count of accepted coins
//   reject_cnt    saturating count of rejected coins
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for coin_present
// DEB   | counting consecutive high samples of coin_present
// MEAS  | accumulating four coin_size samples
// CLASS | one cycle: average the samples and pick a window or reject
// PULSE | one detect line held high for PULSE_LEN cycles
// REJ   | reject held high for PULSE_LEN cycles
// GAP   | waiting for GAP consecutive low cycles of coin_present

module coin_classifier #(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned PULSE_LEN = 8,
  parameter int unsigned GAP       = 40,
  parameter int unsigned MIN_5     = 80,
  parameter int unsigned MAX_5     = 95,
  parameter int unsigned MIN_10    = 60,
  parameter int unsigned MAX_10    = 75,
  parameter int unsigned MIN_25    = 100,
  parameter int unsigned MAX_25    = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_present,
  input  logic [7:0] coin_size,
  output logic       detect_5,
  output logic       detect_10,
  output logic       detect_25,
  output logic       reject,
  output logic       busy,
  output logic [7:0] accept_cnt,
  output logic [7:0] reject_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEB,
    S_MEAS,
    S_CLASS,
    S_PULSE,
    S_REJ,
    S_GAP
  } state_t;

  // DEB leaves on the sample that would bring db_cnt up to DEBOUNCE.
  localparam logic [3:0]  DEB_TC     = 4'(DEBOUNCE - 1);
  // Pulse and gap timers count down to zero, so they load one less than the
  // number of cycles they time.
  localparam logic [7:0]  PULSE_LOAD = 8'(PULSE_LEN - 1);
  localparam logic [15:0] GAP_LOAD   = 16'(GAP - 1);

  localparam logic [7:0] LO_5  = 8'(MIN_5);
  localparam logic [7:0] HI_5  = 8'(MAX_5);
  localparam logic [7:0] LO_10 = 8'(MIN_10);
  localparam logic [7:0] HI_10 = 8'(MAX_10);
  localparam logic [7:0] LO_25 = 8'(MIN_25);
  localparam logic [7:0] HI_25 = 8'(MAX_25);

  state_t      state, state_nxt;
  logic [3:0]  db_cnt, db_cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [9:0]  sum, sum_nxt;
  logic [7:0]  pulse_cnt, pulse_cnt_nxt;
  logic [15:0] gap_cnt, gap_cnt_nxt;
  // One-hot coin select, bit order {25, 10, 5}; drives the detect lines directly.
  logic [2:0]  sel, sel_nxt;
  logic        rej_q, rej_nxt;
  logic        busy_q, busy_nxt;
  logic [7:0]  acc_q, acc_nxt;
  logic [7:0]  rcnt_q, rcnt_nxt;

  logic [7:0]  avg;
  logic        in_5, in_10, in_25;

  assign avg   = sum[9:2];
  assign in_5  = (avg >= LO_5)  && (avg <= HI_5);
  assign in_10 = (avg >= LO_10) && (avg <= HI_10);
  assign in_25 = (avg >= LO_25) && (avg <= HI_25);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      db_cnt    <= '0;
      idx       <= '0;
      sum       <= '0;
      pulse_cnt <= '0;
      gap_cnt   <= '0;
      sel       <= '0;
      rej_q     <= 1'b0;
      busy_q    <= 1'b0;
      acc_q     <= '0;
      rcnt_q    <= '0;
    end else begin
      state     <= state_nxt;
      db_cnt    <= db_cnt_nxt;
      idx       <= idx_nxt;
      sum       <= sum_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      sel       <= sel_nxt;
      rej_q     <= rej_nxt;
      busy_q    <= busy_nxt;
      acc_q     <= acc_nxt;
      rcnt_q    <= rcnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    db_cnt_nxt    = db_cnt;
    idx_nxt       = idx;
    sum_nxt       = sum;
    pulse_cnt_nxt = pulse_cnt;
    gap_cnt_nxt   = gap_cnt;
    sel_nxt       = sel;
    rej_nxt       = rej_q;
    acc_nxt       = acc_q;
    rcnt_nxt      = rcnt_q;

    case (state)
      S_IDLE: begin
        if (coin_present) begin
          state_nxt  = S_DEB;
          db_cnt_nxt = 4'd1;
        end
      end

      S_DEB: begin
        if (!coin_present) begin
          state_nxt = S_IDLE;
        end else if (db_cnt == DEB_TC) begin
          state_nxt = S_MEAS;
          sum_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          db_cnt_nxt = db_cnt + 4'd1;
        end
      end

      S_MEAS: begin
        if (!coin_present) begin
          // The coin left before four samples were taken.
          state_nxt     = S_REJ;
          rej_nxt       = 1'b1;
          pulse_cnt_nxt = PULSE_LOAD;
          if (rcnt_q != 8'hFF) rcnt_nxt = rcnt_q + 8'd1;
        end else begin
          sum_nxt = sum + {2'b00, coin_size};
          if (idx == 2'd3) begin
            state_nxt = S_CLASS;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end

      S_CLASS: begin
        pulse_cnt_nxt = PULSE_LOAD;
        // The windows are checked in priority order 25 > 10 > 5 on overlap.
        if (in_25 || in_10 || in_5) begin
          state_nxt = S_PULSE;
          if (in_25)      sel_nxt = 3'b100;
          else if (in_10) sel_nxt = 3'b010;
          else            sel_nxt = 3'b001;
          if (acc_q != 8'hFF) acc_nxt = acc_q + 8'd1;
        end else begin
          state_nxt = S_REJ;
          rej_nxt   = 1'b1;
          if (rcnt_q != 8'hFF) rcnt_nxt = rcnt_q + 8'd1;
        end
      end

      S_PULSE: begin
        if (pulse_cnt == 8'd0) begin
          state_nxt   = S_GAP;
          sel_nxt     = '0;
          gap_cnt_nxt = GAP_LOAD;
        end else begin
          pulse_cnt_nxt = pulse_cnt - 8'd1;
        end
      end

      S_REJ: begin
        if (pulse_cnt == 8'd0) begin
          state_nxt   = S_GAP;
          rej_nxt     = 1'b0;
          gap_cnt_nxt = GAP_LOAD;
        end else begin
          pulse_cnt_nxt = pulse_cnt - 8'd1;
        end
      end

      S_GAP: begin
        // A lingering or jammed coin restarts the quiet window, so it cannot
        // be counted a second time.
        if (coin_present) begin
          gap_cnt_nxt = GAP_LOAD;
        end else if (gap_cnt == 16'd0) begin
          state_nxt = S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 16'd1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        sel_nxt   = '0;
        rej_nxt   = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  assign detect_5   = sel[0];
  assign detect_10  = sel[1];
  assign detect_25  = sel[2];
  assign reject     = rej_q;
  assign busy       = busy_q;
  assign accept_cnt = acc_q;
  assign reject_cnt = rcnt_q;

endmodule

// File: tb/tb_coin_classifier.sv
module tb_coin_classifier;

  localparam int DEBOUNCE  = 4;
  localparam int PULSE_LEN = 8;
  localparam int GAP       = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_present = 1'b0;
  logic [7:0] coin_size = 8'd0;
  logic       detect_5, detect_10, detect_25, reject, busy;
  logic [7:0] accept_cnt, reject_cnt;

  int checks = 0;
  int errors = 0;
  int exp_acc = 0;
  int exp_rej = 0;

  coin_classifier dut (
    .clk         (clk),
    .reset       (reset),
    .coin_present(coin_present),
    .coin_size   (coin_size),
    .detect_5    (detect_5),
    .detect_10   (detect_10),
    .detect_25   (detect_25),
    .reject      (reject),
    .busy        (busy),
    .accept_cnt  (accept_cnt),
    .reject_cnt  (reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    assert (act === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp_v);
    end
  endtask

  // Coin value from the averaged size: 25/10/5, or 0 for a reject.
  function automatic int classify(input int avg);
    if (avg >= 100 && avg <= 120) return 25;
    if (avg >= 60 && avg <= 75)   return 10;
    if (avg >= 80 && avg <= 95)   return 5;
    return 0;
  endfunction

  // One coin: optional bounce of b high cycles (b < DEBOUNCE) and one low
  // cycle, then coin_present high for `hold` cycles, then low. Edge n = 0 is
  // the first high sample. Expected outputs after every edge come from the
  // timing rules: the pulse starts at the classify edge (or the edge a short
  // coin leaves), and the block goes idle GAP low samples after the pulse.
  // abort_at >= 0 asserts reset on that edge and ends the coin there.
  task automatic run_coin(input int b, input int hold, input int s0, input int s1,
                          input int s2, input int s3, input int abort_at, input string tag);
    int t0, start, kind, idle_e, l, n_last, k, sum;
    int sz[4];
    logic e_busy, rst_now, in_p;
    sz[0] = s0; sz[1] = s1; sz[2] = s2; sz[3] = s3;
    sum   = s0 + s1 + s2 + s3;
    t0    = (b > 0) ? b + 1 : 0;
    start = -1;
    kind  = -1;
    if (hold >= DEBOUNCE + 4) begin
      kind  = classify(sum / 4);
      start = t0 + DEBOUNCE + 4;
    end else if (hold >= DEBOUNCE) begin
      kind  = 0;
      start = t0 + hold;
    end
    if (start >= 0) begin
      l = start + PULSE_LEN + 1;
      if (t0 + hold > l) l = t0 + hold;
      idle_e = l + GAP - 1;
    end else begin
      idle_e = t0 + hold;
    end
    n_last = (abort_at >= 0) ? abort_at : idle_e + 2;

    for (int n = 0; n <= n_last; n++) begin
      @(negedge clk);
      if (b > 0 && n < b)                   coin_present = 1'b1;
      else if (n >= t0 && n < t0 + hold)    coin_present = 1'b1;
      else                                  coin_present = 1'b0;
      k = n - t0 - DEBOUNCE;
      if (coin_present && k >= 0 && k < 4) coin_size = 8'(sz[k]);
      else                                  coin_size = 8'($urandom_range(0, 255));
      rst_now = (n == abort_at);
      if (rst_now) begin
        reset        = 1'b1;
        coin_present = 1'b0;
      end
      @(posedge clk);
      #1;
      if (rst_now) begin
        exp_acc = 0;
        exp_rej = 0;
      end else if (n == start) begin
        if (kind == 0) begin if (exp_rej < 255) exp_rej++; end
        else           begin if (exp_acc < 255) exp_acc++; end
      end
      in_p   = !rst_now && start >= 0 && n >= start && n < start + PULSE_LEN;
      e_busy = !rst_now && (((b > 0) && (n < b)) || (n >= t0 && n < idle_e));
      chk({tag, ".d5"},  32'(detect_5),  32'(in_p && kind == 5));
      chk({tag, ".d10"}, 32'(detect_10), 32'(in_p && kind == 10));
      chk({tag, ".d25"}, 32'(detect_25), 32'(in_p && kind == 25));
      chk({tag, ".rej"}, 32'(reject),    32'(in_p && kind == 0));
      chk({tag, ".busy"}, 32'(busy),     32'(e_busy));
      chk({tag, ".acc"}, 32'(accept_cnt), 32'(exp_acc));
      chk({tag, ".rcnt"}, 32'(reject_cnt), 32'(exp_rej));
    end
    if (abort_at >= 0) begin
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  initial begin
    int v, b, h;
    reset        = 1'b1;
    coin_present = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.d5", 32'(detect_5), 0);
    chk("rst.d10", 32'(detect_10), 0);
    chk("rst.d25", 32'(detect_25), 0);
    chk("rst.rej", 32'(reject), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.acc", 32'(accept_cnt), 0);
    chk("rst.rcnt", 32'(reject_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_coin(0, 20, 68, 68, 68, 68, -1, "clean10");
    run_coin(2, 20, 110, 110, 110, 110, -1, "bounce25");
    run_coin(0, 20, 50, 50, 50, 50, -1, "oow");
    run_coin(0, 12, 95, 95, 95, 96, -1, "avg95");
    run_coin(0, 12, 96, 96, 96, 96, -1, "avg96");
    run_coin(0, 200, 88, 88, 88, 88, -1, "linger");
    run_coin(0, DEBOUNCE + 2, 70, 70, 70, 70, -1, "short");
    run_coin(0, DEBOUNCE, 70, 70, 70, 70, -1, "short0");
    run_coin(1, 2, 70, 70, 70, 70, -1, "deb_abort");
    run_coin(0, DEBOUNCE + 5, 60, 60, 60, 60, -1, "edge60");
    run_coin(0, DEBOUNCE + 5, 120, 120, 120, 123, -1, "edge120");
    run_coin(0, DEBOUNCE + 5, 121, 121, 121, 121, -1, "over120");

    for (int i = 0; i < 30; i++) begin
      b = $urandom_range(0, DEBOUNCE - 1);
      h = $urandom_range(1, 30);
      run_coin(b, h, $urandom_range(50, 130), $urandom_range(50, 130),
               $urandom_range(50, 130), $urandom_range(50, 130), -1, "rand");
    end

    for (int i = 0; i < 260; i++) begin
      v = $urandom_range(100, 120);
      run_coin(0, DEBOUNCE + 4 + $urandom_range(0, 3), v, v, v, v, -1, "sat");
    end
    chk("sat.final", 32'(accept_cnt), 255);

    // Reset three cycles into a detect pulse.
    run_coin(0, 20, 68, 68, 68, 68, DEBOUNCE + 4 + 3, "rstpulse");
    @(negedge clk);
    #1;
    chk("post_rst.busy", 32'(busy), 0);
    chk("post_rst.acc", 32'(accept_cnt), 0);
    run_coin(0, 20, 85, 85, 85, 85, -1, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
